bus_grant_arbiter: RTL



---
 rtl/cpu_bus_pkg.sv | 45 ++++
 rtl/bus_grant_arbiter_rr_pick.sv | 48 ++++
 rtl/bus_grant_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus path: source count, arbiter state encoding,
// and bus-source indices agreed with the 32-to-5 bus-select encoder.
package cpu_bus_pkg;

    localparam int N     = 32;
    localparam int IDX_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] SRC_R0     = 5'd0;
    localparam logic [IDX_W-1:0] SRC_R1     = 5'd1;
    localparam logic [IDX_W-1:0] SRC_R2     = 5'd2;
    localparam logic [IDX_W-1:0] SRC_R3     = 5'd3;
    localparam logic [IDX_W-1:0] SRC_R4     = 5'd4;
    localparam logic [IDX_W-1:0] SRC_R5     = 5'd5;
    localparam logic [IDX_W-1:0] SRC_R6     = 5'd6;
    localparam logic [IDX_W-1:0] SRC_R7     = 5'd7;
    localparam logic [IDX_W-1:0] SRC_R8     = 5'd8;
    localparam logic [IDX_W-1:0] SRC_R9     = 5'd9;
    localparam logic [IDX_W-1:0] SRC_R10    = 5'd10;
    localparam logic [IDX_W-1:0] SRC_R11    = 5'd11;
    localparam logic [IDX_W-1:0] SRC_R12    = 5'd12;
    localparam logic [IDX_W-1:0] SRC_R13    = 5'd13;
    localparam logic [IDX_W-1:0] SRC_R14    = 5'd14;
    localparam logic [IDX_W-1:0] SRC_R15    = 5'd15;
    localparam logic [IDX_W-1:0] SRC_HI     = 5'd16;
    localparam logic [IDX_W-1:0] SRC_LO     = 5'd17;
    localparam logic [IDX_W-1:0] SRC_PC     = 5'd18;
    localparam logic [IDX_W-1:0] SRC_MDR    = 5'd19;
    localparam logic [IDX_W-1:0] SRC_ZLO    = 5'd20;
    localparam logic [IDX_W-1:0] SRC_ZHI    = 5'd21;
    localparam logic [IDX_W-1:0] SRC_INPORT = 5'd22;
    localparam logic [IDX_W-1:0] SRC_CSIGN  = 5'd23;

    function automatic logic [N-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] one;
        one      = {{(N-1){1'b0}}, 1'b1};
        f_onehot = one << idx;
    endfunction

endpackage

// File: rtl/bus_grant_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests so the search starts just
// above the last owner, take the lowest set bit, then map back to a source index.
module rr_pick
    import cpu_bus_pkg::*;
(
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last_ptr,
    output logic [IDX_W-1:0] o_pick_idx,
    output logic             o_pick_valid,
    output logic             o_multi
);

    logic [IDX_W-1:0] w_start;
    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic             w_found;
    logic [IDX_W:0]   w_sum;

    assign w_start = (i_last_ptr == IDX_W'(N-1)) ? {IDX_W{1'b0}} : (i_last_ptr + {{(IDX_W-1){1'b0}}, 1'b1});

    // Rotate so that bit 0 of w_rot is source w_start.
    always_comb begin
        w_rot = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            w_rot[i] = i_req[(int'(w_start) + i) % N];
        end
    end

    // Lowest set bit of the rotated vector.
    always_comb begin
        w_off   = {IDX_W{1'b0}};
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && w_rot[i]) begin
                w_off   = IDX_W'(i);
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    assign w_sum        = {1'b0, w_start} + {1'b0, w_off};
    assign o_pick_idx   = (w_sum >= (IDX_W+1)'(N)) ? IDX_W'(w_sum - (IDX_W+1)'(N)) : IDX_W'(w_sum);
    assign o_pick_valid = |i_req;
    assign o_multi      = |(i_req & (i_req - {{(N-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin bus arbiter: one-hot registered grant for the bus-select encoder,
// no pre-emption, and a mandatory all-zero turnaround cycle between owners.
module bus_grant_arbiter
    import cpu_bus_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic [N-1:0]     i_req,
    input  logic             i_release,
    output logic [N-1:0]     o_grant,
    output logic             o_grant_valid,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_conflict,
    output logic             o_busy
);

    state_t           r_state;
    logic [N-1:0]     r_grant;
    logic             r_grant_valid;
    logic [IDX_W-1:0] r_grant_idx;
    logic             r_conflict;
    logic             r_busy;
    logic [IDX_W-1:0] r_last_ptr;

    state_t           w_state;
    logic [N-1:0]     w_grant;
    logic             w_grant_valid;
    logic [IDX_W-1:0] w_grant_idx;
    logic             w_conflict;
    logic             w_busy;
    logic [IDX_W-1:0] w_last_ptr;

    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic             w_multi;

    rr_pick u_rr_pick (
        .i_req        (i_req),
        .i_last_ptr   (r_last_ptr),
        .o_pick_idx   (w_pick_idx),
        .o_pick_valid (w_pick_valid),
        .o_multi      (w_multi)
    );

    // Next-state and next-output decode; grant_idx is kept after release as a debug trace.
    always_comb begin
        w_state       = r_state;
        w_grant       = r_grant;
        w_grant_valid = r_grant_valid;
        w_grant_idx   = r_grant_idx;
        w_conflict    = 1'b0;
        w_busy        = r_busy;
        w_last_ptr    = r_last_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state       = ST_OWNED;
                    w_grant       = f_onehot(w_pick_idx);
                    w_grant_valid = 1'b1;
                    w_grant_idx   = w_pick_idx;
                    w_conflict    = w_multi;
                    w_busy        = 1'b1;
                    w_last_ptr    = w_pick_idx;
                end else begin
                    w_grant       = {N{1'b0}};
                    w_grant_valid = 1'b0;
                    w_busy        = 1'b0;
                end
            end
            ST_OWNED: begin
                if (i_release || !i_req[r_grant_idx]) begin
                    w_state       = ST_TURN;
                    w_grant       = {N{1'b0}};
                    w_grant_valid = 1'b0;
                    w_busy        = 1'b1;
                end else begin
                    w_state       = ST_OWNED;
                end
            end
            ST_TURN: begin
                w_state       = ST_IDLE;
                w_grant       = {N{1'b0}};
                w_grant_valid = 1'b0;
                w_busy        = 1'b0;
            end
            default: begin
                w_state       = ST_IDLE;
                w_grant       = {N{1'b0}};
                w_grant_valid = 1'b0;
                w_busy        = 1'b0;
            end
        endcase
    end

    // State and output registers; clr overrides everything.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state       <= ST_IDLE;
            r_grant       <= {N{1'b0}};
            r_grant_valid <= 1'b0;
            r_grant_idx   <= {IDX_W{1'b0}};
            r_conflict    <= 1'b0;
            r_busy        <= 1'b0;
            r_last_ptr    <= IDX_W'(N-1);
        end else begin
            r_state       <= w_state;
            r_grant       <= w_grant;
            r_grant_valid <= w_grant_valid;
            r_grant_idx   <= w_grant_idx;
            r_conflict    <= w_conflict;
            r_busy        <= w_busy;
            r_last_ptr    <= w_last_ptr;
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_valid = r_grant_valid;
    assign o_grant_idx   = r_grant_idx;
    assign o_conflict    = r_conflict;
    assign o_busy        = r_busy;

endmodule
